// File: rtl/sync_fifo_core_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_core_if
// Brief    : Producer/consumer bundle for sync_fifo_core; the FIFO sits on
//            the slave side, the control logic on the master side.
// Revision : 1.0 - initial release
// ============================================================================
interface sync_fifo_core_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic [DATA_W-1:0] din;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output din, wr_en, rd_en,
        input  dout, rd_valid, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  din, wr_en, rd_en,
        output dout, rd_valid, full, empty, almost_full, count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_core
// Brief    : Single-clock byte FIFO with registered read, occupancy count,
//            almost-full and overflow/underflow pulses.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_core #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int AFULL_TH = 28
) (
    input  logic             sysclk,
    input  logic             rst,
    sync_fifo_core_if.slave  bus
);
    localparam int              c_DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_ONE      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] c_FULL_CNT = (ADDR_W+1)'(c_DEPTH);
    localparam logic [ADDR_W:0] c_AFULL    = (ADDR_W+1)'(AFULL_TH);

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   r_rptr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_dout;
    logic              r_rd_valid;
    logic              r_full;
    logic              r_empty;
    logic              r_almost_full;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [ADDR_W:0]   w_count_nxt;

    // Acceptance is judged on the registered flags, so a full FIFO still
    // takes a read and an empty one still takes a write in the same cycle.
    assign w_wr_acc = bus.wr_en & ~r_full;
    assign w_rd_acc = bus.rd_en & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + c_ONE;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - c_ONE;
        end
    end

    // Array contents are not reset; the pointers alone define validity.
    always_ff @(posedge sysclk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wptr[ADDR_W-1:0]] <= bus.din;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_dout        <= '0;
            r_rd_valid    <= 1'b0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + c_ONE;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + c_ONE;
                r_dout <= r_mem[r_rptr[ADDR_W-1:0]];
            end
            r_rd_valid    <= w_rd_acc;
            r_count       <= w_count_nxt;
            r_full        <= (w_count_nxt == c_FULL_CNT);
            r_empty       <= (w_count_nxt == '0);
            r_almost_full <= (w_count_nxt >= c_AFULL);
            r_overflow    <= bus.wr_en & r_full;
            r_underflow   <= bus.rd_en & r_empty;
        end
    end

    assign bus.dout        = r_dout;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.full        = r_full;
    assign bus.empty       = r_empty;
    assign bus.almost_full = r_almost_full;
    assign bus.count       = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_core
// Brief    : Directed bench for sync_fifo_core with a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_core;
    localparam int c_DATA_W   = 8;
    localparam int c_ADDR_W   = 5;
    localparam int c_AFULL_TH = 28;
    localparam int c_DEPTH    = 1 << c_ADDR_W;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;

    sync_fifo_core_if #(.DATA_W(c_DATA_W), .ADDR_W(c_ADDR_W)) bus ();

    sync_fifo_core #(
        .DATA_W   (c_DATA_W),
        .ADDR_W   (c_ADDR_W),
        .AFULL_TH (c_AFULL_TH)
    ) u_dut (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    always #5 sysclk = ~sysclk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_q   [$];
    logic [7:0] exp_q [$];
    logic [7:0] m_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, advance the reference model, then check 1 ns after the edge.
    task automatic step(input logic r, input logic wr, input logic rd, input logic [7:0] d);
        logic m_full, m_empty, wacc, racc, e_ovf, e_unf;
        logic [7:0] e_dout;
        rst       = r;
        bus.wr_en = wr;
        bus.rd_en = rd;
        bus.din   = d;
        m_full  = (m_q.size() == c_DEPTH);
        m_empty = (m_q.size() == 0);
        wacc  = wr & ~m_full;
        racc  = rd & ~m_empty;
        e_ovf = wr & m_full;
        e_unf = rd & m_empty;
        if (r) begin
            m_q.delete();
            exp_q.delete();
            m_dout = 8'h00;
            wacc = 1'b0; racc = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
        end else begin
            if (racc) begin
                m_dout = m_q.pop_front();
                exp_q.push_back(m_dout);
            end
            if (wacc) m_q.push_back(d);
        end
        @(posedge sysclk);
        #1;
        chk("count",       32'(bus.count), 32'(m_q.size()));
        chk("full",        32'(bus.full),  32'(m_q.size() == c_DEPTH));
        chk("empty",       32'(bus.empty), 32'(m_q.size() == 0));
        chk("almost_full", 32'(bus.almost_full), 32'(m_q.size() >= c_AFULL_TH));
        chk("overflow",    32'(bus.overflow),  32'(e_ovf));
        chk("underflow",   32'(bus.underflow), 32'(e_unf));
        chk("rd_valid",    32'(bus.rd_valid),  32'(racc));
        if (racc && exp_q.size() != 0) begin
            e_dout = exp_q.pop_front();
            chk("dout_read", 32'(bus.dout), 32'(e_dout));
        end else begin
            chk("dout_hold", 32'(bus.dout), 32'(m_dout));
        end
    endtask

    initial begin
        bus.din   = 8'h00;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;

        // Reset with both requests asserted: they must be ignored.
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        chk("reset_dout", 32'(bus.dout), 32'h0);

        // Fill with 0x01..0x20, then try to overflow with 0xAA.
        for (int i = 1; i <= c_DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        chk("fill_full",  32'(bus.full),  32'd1);
        chk("fill_count", 32'(bus.count), 32'd32);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'hAA);
        chk("ovf_pulse", 32'(bus.overflow), 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ovf_clear", 32'(bus.overflow), 32'd0);

        // Drain: 0x01..0x20 back-to-back, no 0xAA.
        for (int i = 1; i <= c_DEPTH; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk("drain_seq", 32'(bus.dout), 32'(i));
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);

        // Simultaneous on empty: write wins, underflow pulses.
        step(1'b0, 1'b1, 1'b1, 8'h55);
        chk("unf_pulse", 32'(bus.underflow), 32'd1);
        chk("unf_count", 32'(bus.count), 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("unf_read", 32'(bus.dout), 32'h55);

        // Simultaneous on full: read wins, overflow pulses, count 31.
        for (int i = 0; i < c_DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
        step(1'b0, 1'b1, 1'b1, 8'hEE);
        chk("full_both_ovf",   32'(bus.overflow), 32'd1);
        chk("full_both_count", 32'(bus.count), 32'd31);
        chk("full_both_dout",  32'(bus.dout), 32'h80);
        for (int i = 0; i < c_DEPTH - 1; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

        // Streaming across several pointer wraps with 3 words resident.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        for (int i = 3; i < 103; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'(i));
            chk("wrap_count", 32'(bus.count), 32'd3);
            chk("wrap_dout",  32'(bus.dout), 32'(8'(i - 3)));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

        // Reset in the middle of a read burst.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 8'h7E);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("post_rst_read", 32'(bus.dout), 32'h7E);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
